// File: rtl/life_pkg.sv
// Shared constants for the Game-of-Life scheduler: FSM encoding, colours,
// screen geometry and a grid bounds helper.
package life_pkg;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_USER_DRAW = 3'd1;
   localparam logic [2:0] S_SIM_WAIT  = 3'd2;
   localparam logic [2:0] S_FETCH     = 3'd3;
   localparam logic [2:0] S_PAINT     = 3'd4;

   localparam logic [2:0] COLOR_ALIVE = 3'b111;
   localparam logic [2:0] COLOR_DEAD  = 3'b000;

   localparam int VGA_W = 160;
   localparam int VGA_H = 120;

   function automatic logic cell_in_range(input logic [7:0] x, input logic [7:0] y,
                                          input int grid_w, input int grid_h);
      return (int'(x) < grid_w) && (int'(y) < grid_h);
   endfunction

endpackage

// File: rtl/life_scheduler_raster.sv
// Pixel-offset counter that walks one CELL_PX x CELL_PX block, px fastest.
module cell_raster
   import life_pkg::*;
#(
   parameter int CELL_PX = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic       advance,
   output logic [3:0] px,
   output logic [3:0] py,
   output logic       last
);

   localparam logic [3:0] LAST_OFS = 4'(CELL_PX - 1);

   logic [3:0] px_r;
   logic [3:0] py_r;

   // Offset counters; start re-arms the block origin, advance steps one pixel.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         px_r <= 4'd0;
         py_r <= 4'd0;
      end else if (start) begin
         px_r <= 4'd0;
         py_r <= 4'd0;
      end else if (advance) begin
         if (px_r == LAST_OFS) begin
            px_r <= 4'd0;
            if (py_r == LAST_OFS) begin
               py_r <= 4'd0;
            end else begin
               py_r <= py_r + 4'd1;
            end
         end else begin
            px_r <= px_r + 4'd1;
            py_r <= py_r;
         end
      end else begin
         px_r <= px_r;
         py_r <= py_r;
      end
   end

   assign px   = px_r;
   assign py   = py_r;
   assign last = (px_r == LAST_OFS) && (py_r == LAST_OFS);

endmodule

// File: rtl/life_scheduler.sv
// Generation sequencer and sole owner of the VGA plot port: user cell edits
// and changed-cell repaint share one raster engine.
module life_scheduler
   import life_pkg::*;
#(
   parameter int GRID_W   = 4,
   parameter int GRID_H   = 4,
   parameter int CELL_PX  = 8,
   parameter int ORIGIN_X = 0,
   parameter int ORIGIN_Y = 0,
   parameter int TICK_DIV = 500000,
   parameter int CNT_W    = 20
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        run,
   input  logic        step,
   input  logic        usr_req,
   input  logic [7:0]  usr_x,
   input  logic [7:0]  usr_y,
   input  logic        usr_alive,
   output logic        usr_ack,
   output logic        sim_go,
   input  logic        sim_done,
   input  logic [7:0]  sim_count,
   input  logic [7:0]  chg_x,
   input  logic [7:0]  chg_y,
   input  logic [2:0]  chg_color,
   output logic        chg_rd,
   output logic        plot,
   output logic [7:0]  plot_x,
   output logic [7:0]  plot_y,
   output logic [2:0]  plot_color,
   output logic        busy,
   output logic [15:0] gen_count
);

   localparam logic [CNT_W-1:0] TICK_RELOAD = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]       state_r;
   logic [2:0]       state_n_s;
   logic [CNT_W-1:0] tick_cnt_r;
   logic             tick_s;
   logic             pend_gen_r;
   logic [7:0]       cell_x_r;
   logic [7:0]       cell_y_r;
   logic [2:0]       cell_color_r;
   logic [7:0]       remaining_r;
   logic [15:0]      gen_count_r;

   logic             consume_s;
   logic             ras_adv_s;
   logic             ras_start_s;
   logic             ras_last_s;
   logic             ack_s;
   logic             gen_inc_s;
   logic             rem_dec_s;
   logic             cell_ok_s;
   logic             chg_ok_s;
   logic [3:0]       px_s;
   logic [3:0]       py_s;
   logic [7:0]       pix_x_s;
   logic [7:0]       pix_y_s;

   logic             plot_r;
   logic [7:0]       plot_x_r;
   logic [7:0]       plot_y_r;
   logic [2:0]       plot_color_r;
   logic             usr_ack_r;
   logic             sim_go_r;
   logic             chg_rd_r;
   logic             busy_r;

   cell_raster #(
      .CELL_PX (CELL_PX)
   ) u_raster (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (ras_start_s),
      .advance (ras_adv_s),
      .px      (px_s),
      .py      (py_s),
      .last    (ras_last_s)
   );

   assign tick_s      = run && (tick_cnt_r == CNT_ZERO);
   assign cell_ok_s   = cell_in_range(cell_x_r, cell_y_r, GRID_W, GRID_H);
   assign chg_ok_s    = cell_in_range(chg_x, chg_y, GRID_W, GRID_H);
   assign ras_start_s = (state_r == S_IDLE) || (state_r == S_FETCH);
   // 8-bit arithmetic gives the required truncation for free.
   assign pix_x_s     = 8'(ORIGIN_X) + cell_x_r * 8'(CELL_PX) + {4'd0, px_s};
   assign pix_y_s     = 8'(ORIGIN_Y) + cell_y_r * 8'(CELL_PX) + {4'd0, py_s};

   // Next-state and per-cycle action decode.
   always_comb begin
      state_n_s = state_r;
      consume_s = 1'b0;
      ras_adv_s = 1'b0;
      ack_s     = 1'b0;
      gen_inc_s = 1'b0;
      rem_dec_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (usr_req) begin
               state_n_s = S_USER_DRAW;
            end else if (pend_gen_r) begin
               consume_s = 1'b1;
               state_n_s = S_SIM_WAIT;
            end else begin
               state_n_s = S_IDLE;
            end
         end
         S_USER_DRAW: begin
            if (!cell_ok_s) begin
               ack_s     = 1'b1;
               state_n_s = S_IDLE;
            end else begin
               ras_adv_s = 1'b1;
               if (ras_last_s) begin
                  ack_s     = 1'b1;
                  state_n_s = S_IDLE;
               end else begin
                  state_n_s = S_USER_DRAW;
               end
            end
         end
         S_SIM_WAIT: begin
            if (sim_done) begin
               if (sim_count == 8'd0) begin
                  gen_inc_s = 1'b1;
                  state_n_s = S_IDLE;
               end else begin
                  state_n_s = S_FETCH;
               end
            end else begin
               state_n_s = S_SIM_WAIT;
            end
         end
         S_FETCH: begin
            if (chg_ok_s) begin
               state_n_s = S_PAINT;
            end else begin
               rem_dec_s = 1'b1;
               if (remaining_r == 8'd1) begin
                  gen_inc_s = 1'b1;
                  state_n_s = S_IDLE;
               end else begin
                  state_n_s = S_FETCH;
               end
            end
         end
         S_PAINT: begin
            ras_adv_s = 1'b1;
            if (ras_last_s) begin
               rem_dec_s = 1'b1;
               if (remaining_r == 8'd1) begin
                  gen_inc_s = 1'b1;
                  state_n_s = S_IDLE;
               end else begin
                  state_n_s = S_FETCH;
               end
            end else begin
               state_n_s = S_PAINT;
            end
         end
         default: begin
            state_n_s = S_IDLE;
         end
      endcase
   end

   // FSM state, generation tick, latched cell and change-list bookkeeping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= S_IDLE;
         tick_cnt_r   <= TICK_RELOAD;
         pend_gen_r   <= 1'b0;
         cell_x_r     <= 8'd0;
         cell_y_r     <= 8'd0;
         cell_color_r <= 3'd0;
         remaining_r  <= 8'd0;
         gen_count_r  <= 16'd0;
      end else begin
         state_r <= state_n_s;

         if (run) begin
            if (tick_s) begin
               tick_cnt_r <= TICK_RELOAD;
            end else begin
               tick_cnt_r <= tick_cnt_r - CNT_ONE;
            end
         end else begin
            tick_cnt_r <= tick_cnt_r;
         end

         if (consume_s) begin
            pend_gen_r <= 1'b0;
         end else if (tick_s || (step && !run)) begin
            pend_gen_r <= 1'b1;
         end else begin
            pend_gen_r <= pend_gen_r;
         end

         if ((state_r == S_IDLE) && usr_req) begin
            cell_x_r     <= usr_x;
            cell_y_r     <= usr_y;
            cell_color_r <= usr_alive ? COLOR_ALIVE : COLOR_DEAD;
         end else if (state_r == S_FETCH) begin
            cell_x_r     <= chg_x;
            cell_y_r     <= chg_y;
            cell_color_r <= chg_color;
         end else begin
            cell_x_r     <= cell_x_r;
            cell_y_r     <= cell_y_r;
            cell_color_r <= cell_color_r;
         end

         if ((state_r == S_SIM_WAIT) && sim_done) begin
            remaining_r <= sim_count;
         end else if (rem_dec_s) begin
            remaining_r <= remaining_r - 8'd1;
         end else begin
            remaining_r <= remaining_r;
         end

         if (gen_inc_s) begin
            gen_count_r <= gen_count_r + 16'd1;
         end else begin
            gen_count_r <= gen_count_r;
         end
      end
   end

   // Registered port outputs; chg_rd is decoded from next state so it is high during FETCH.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         plot_r       <= 1'b0;
         plot_x_r     <= 8'd0;
         plot_y_r     <= 8'd0;
         plot_color_r <= 3'd0;
         usr_ack_r    <= 1'b0;
         sim_go_r     <= 1'b0;
         chg_rd_r     <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         plot_r <= ras_adv_s;
         if (ras_adv_s) begin
            plot_x_r     <= pix_x_s;
            plot_y_r     <= pix_y_s;
            plot_color_r <= cell_color_r;
         end else begin
            plot_x_r     <= plot_x_r;
            plot_y_r     <= plot_y_r;
            plot_color_r <= plot_color_r;
         end
         usr_ack_r <= ack_s;
         sim_go_r  <= consume_s;
         chg_rd_r  <= (state_n_s == S_FETCH);
         busy_r    <= (state_r != S_IDLE);
      end
   end

   assign plot       = plot_r;
   assign plot_x     = plot_x_r;
   assign plot_y     = plot_y_r;
   assign plot_color = plot_color_r;
   assign usr_ack    = usr_ack_r;
   assign sim_go     = sim_go_r;
   assign chg_rd     = chg_rd_r;
   assign busy       = busy_r;
   assign gen_count  = gen_count_r;

endmodule
